// File: rtl/div_manager_pkg.sv
// Shared definitions for the divide manager slice.
//   - div_op_e      : RV32M divide opcodes as presented on op_i
//   - divm_state_e  : manager FSM states
//   - op_is_signed / op_is_rem : opcode decode helpers
package div_manager_pkg;

  localparam int DIVM_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIVM_IDLE = 2'd0,
    DIVM_CALC = 2'd1,
    DIVM_DONE = 2'd2
  } divm_state_e;

  // DIV and REM are the signed flavours; bit 0 of the encoding marks unsigned.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder; bit 1 of the encoding selects it.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider, one iteration per clock.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor and begin ITER_CYCLES iterations
//   dividend  : unsigned dividend (sampled on start)
//   divisor   : unsigned divisor, non-zero (sampled on start)
//   done      : high during the cycle whose closing edge performs the last iteration
//   quotient  : partial quotient after this cycle's iteration
//   remainder : partial remainder after this cycle's iteration
// quotient/remainder are the combinational result of the current iteration, so
// while done is high they are the final values and the owner can capture them on
// the same edge that retires the operation.
module div_core
  import div_manager_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            running;
  logic [4:0]      cnt;
  logic [XLEN-1:0] q_r;   // dividend bits shift out the top, quotient bits shift in
  logic [XLEN-1:0] r_r;
  logic [XLEN-1:0] d_r;

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [XLEN:0] r_sh;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    r_sh      = {r_r, q_r[XLEN-1]};
    diff      = r_sh - {1'b0, d_r};
    fits      = ~diff[XLEN];
    quotient  = {q_r[XLEN-2:0], fits};
    remainder = fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    done      = running && (cnt == 5'(ITER_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      d_r     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      q_r     <= dividend;
      r_r     <= '0;
      d_r     <= divisor;
    end else if (running) begin
      q_r <= quotient;
      r_r <= remainder;
      cnt <= cnt + 5'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/div_manager.sv
// RV32M divide manager: owns div_core, runs DIV/DIVU/REM/REMU one at a time.
//   clk, rst         : clock, synchronous active-high reset
//   issue_*          : op intake from EX (valid/ready), op_i/rs1/rs2/rd
//   rd_addr_flags_o  : one-hot pending destination, for hazard stalls
//   busy_o           : FSM not idle
//   wb_*             : result to WB arbiter (valid/ready), held until accepted
// Divide-by-zero and signed overflow are answered directly at accept; other
// ops run the core on magnitudes and apply sign fix-up when entering DONE.
module div_manager
  import div_manager_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic [31:0]     rd_addr_flags_o,
  output logic            busy_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  input  logic            wb_ready_i
);

  divm_state_e state_q;

  logic       rem_q;     // return remainder rather than quotient
  logic       neg_q_q;   // negate quotient at fix-up
  logic       neg_r_q;   // negate remainder at fix-up
  logic [4:0] rd_q;

  logic            accept;
  logic            sgn, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  logic            core_done;
  logic [XLEN-1:0] core_q, core_r, q_fix, r_fix, calc_res;

  assign issue_ready_o = (state_q == DIVM_IDLE);
  assign busy_o        = (state_q != DIVM_IDLE);
  assign accept        = issue_valid_i && issue_ready_o;

  always_comb begin
    sgn     = op_is_signed(op_i);
    a_neg   = sgn & rs1_data_i[XLEN-1];
    b_neg   = sgn & rs2_data_i[XLEN-1];
    a_mag   = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
    b_mag   = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
    div0    = (rs2_data_i == '0);
    ovf     = sgn && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
    special = div0 | ovf;
    // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div0) special_res = op_is_rem(op_i) ? rs1_data_i : '1;
    else      special_res = op_is_rem(op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    q_fix    = neg_q_q ? (~core_q + 1'b1) : core_q;
    r_fix    = neg_r_q ? (~core_r + 1'b1) : core_r;
    calc_res = rem_q ? r_fix : q_fix;
  end

  div_core #(
    .XLEN        (XLEN),
    .ITER_CYCLES (ITER_CYCLES)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && !special),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= DIVM_IDLE;
      rem_q           <= 1'b0;
      neg_q_q         <= 1'b0;
      neg_r_q         <= 1'b0;
      rd_q            <= '0;
      rd_addr_flags_o <= '0;
      wb_valid_o      <= 1'b0;
      wb_rd_addr_o    <= '0;
      wb_data_o       <= '0;
    end else begin
      case (state_q)
        DIVM_IDLE: begin
          if (accept) begin
            rd_q            <= rd_addr_i;
            rem_q           <= op_is_rem(op_i);
            neg_q_q         <= a_neg ^ b_neg;
            neg_r_q         <= a_neg;
            // x0 writes are discarded, so never mark it pending.
            rd_addr_flags_o <= (rd_addr_i != '0) ? (32'd1 << rd_addr_i) : '0;
            if (special) begin
              state_q      <= DIVM_DONE;
              wb_data_o    <= special_res;
              wb_rd_addr_o <= rd_addr_i;
              wb_valid_o   <= (rd_addr_i != '0);
            end else begin
              state_q <= DIVM_CALC;
            end
          end
        end
        DIVM_CALC: begin
          if (core_done) begin
            state_q      <= DIVM_DONE;
            wb_data_o    <= calc_res;
            wb_rd_addr_o <= rd_q;
            wb_valid_o   <= (rd_q != '0);
          end
        end
        DIVM_DONE: begin
          // An rd==0 op never raised valid: it retires silently after one cycle.
          if (!wb_valid_o || wb_ready_i) begin
            state_q         <= DIVM_IDLE;
            wb_valid_o      <= 1'b0;
            rd_addr_flags_o <= '0;
          end
        end
        default: state_q <= DIVM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_manager.md
Name: div_manager

Overview:
- Owns the iterative integer divider and executes RV32M DIV/DIVU/REM/REMU.
- Accepts one operation from EX through a valid/ready handshake and tracks the pending destination register as a one-hot 32-bit flag vector. The stall controller consumes this vector to hold ID on RAW/WAW hazards.
- Returns the result through a valid/ready writeback port to the WB arbiter.
- One operation is in flight at a time. Accepted operations are architecturally committed; there is no flush input.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_CYCLES, 32, CALC-state cycles for the non-special path; must equal XLEN (radix-2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  EX presents a divide op
- issue_ready_o  out  1  block can accept an op
- op_i  in  2  operation code: DIV, DIVU, REM or REMU (encodings in defines.vh)
- rs1_data_i  in  32  dividend
- rs2_data_i  in  32  divisor
- rd_addr_i  in  5  destination register
- rd_addr_flags_o  out  32  one-hot pending-rd vector, consumed by the stall controller
- busy_o  out  1  state != IDLE
- wb_valid_o  out  1  result available
- wb_rd_addr_o  out  5  result destination
- wb_data_o  out  32  quotient or remainder
- wb_ready_i  in  1  WB arbiter accepts the result

Behaviour:
- Reset (rst high at a rising edge):
  - State becomes IDLE, including mid-operation; any in-flight op is discarded.
  - All outputs go to 0 except issue_ready_o, which is 1.
- States: IDLE, CALC, DONE.
- issue_ready_o = (state==IDLE), combinational from registered state.
- Accept occurs when issue_valid_i && issue_ready_o at edge T:
  - Latch op, operands and rd.
  - If rd!=0, set rd_addr_flags_o[rd] from cycle T+1. Bit 0 is never set.
- Special cases are resolved at accept and go IDLE->DONE, so wb_valid_o is asserted in cycle T+1:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient 0x80000000; remainder 0.
- Normal path: IDLE->CALC.
  - Signed ops use operand magnitudes.
  - Run ITER_CYCLES restoring iterations in div_core, one per cycle.
  - CALC->DONE after the last iteration; wb_valid_o is asserted in cycle T+33.
- Sign fix-up happens on the DONE-entry edge:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIVU/REMU results are unsigned.
- DONE state:
  - wb_valid_o=1; wb_rd_addr_o and wb_data_o are stable, and held while wb_ready_i=0 for any number of cycles.
  - On wb_valid_o && wb_ready_i at an edge: go to IDLE and clear the flag bit on that same edge. The new op can be accepted at the next edge.
- rd==0: the computation runs normally, but DONE->IDLE occurs without asserting wb_valid_o; the flags stay all-zero.
- rd_addr_flags_o is a registered output with at most one bit set.
- Same-cycle flag set and clear cannot occur, because issue is only accepted in IDLE.

Decomposition:
- defines.vh:
  - DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11.
  - State encodings DIVM_IDLE/CALC/DONE.
- Sub-module div_core: unsigned restoring divider.
  - Ports: clk, rst, start, dividend, divisor, done, quotient, remainder.
  - 5-bit iteration counter.
- div_manager holds the FSM, sign handling, special cases, flags and writeback registers.

Test Plan:
- DIVU: 100/7, rd=5, accepted at edge T.
  - rd_addr_flags_o=0x00000020 from T+1 until the handshake.
  - wb_valid_o at T+33 with wb_data_o=14, wb_rd_addr_o=5.
  - The flag clears on the handshake edge.
- REM: 0xFFFFFFF9 % 2 (-7 % 2), rd=3 -> wb_data_o=0xFFFFFFFF. DIV with the same operands -> 0xFFFFFFFD.
- DIV x/0 with x=0x12345678 -> wb_valid_o at T+1 with data 0xFFFFFFFF. REM with the same operands -> 0x12345678.
- DIV: 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM with the same operands -> 0.
- Backpressure and reset:
  - Hold wb_ready_i=0 for 5 cycles in DONE: data, rd and flags are stable; issue_ready_o=0; issue_valid_i is ignored.
  - Raise wb_ready_i: IDLE the next cycle.
- rd=0 op: flags stay 0x0 and wb_valid_o never asserts. issue_ready_o returns to 1 at T+34 (T+2 for a special case).
- Reset mid-CALC:
  - Assert rst 10 cycles after accept: next cycle flags=0, wb_valid_o=0, busy_o=0, issue_ready_o=1.
  - A fresh DIVU 9/3 then returns 3.
